// File: rtl/sync_debounce_if.sv
// sync_debounce_if: groups the conditioned-level signals of sync_debounce.
//   d_in  raw asynchronous level (toward the debouncer)
//   q     debounced, registered level
//   rise  one-cycle pulse when q goes 0->1
//   fall  one-cycle pulse when q goes 1->0
//   busy  a candidate level change is being counted
// master: the side that supplies d_in and consumes the conditioned outputs.
// slave:  the debouncer itself.
interface sync_debounce_if;
   logic d_in;
   logic q;
   logic rise;
   logic fall;
   logic busy;

   modport master (
      output d_in,
      input  q,
      input  rise,
      input  fall,
      input  busy
   );

   modport slave (
      input  d_in,
      output q,
      output rise,
      output fall,
      output busy
   );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: input conditioning stage feeding a register's d input.
// A SYNC_STAGES-deep synchronizer brings the raw level into the clock domain,
// then a two-state FSM with a stability counter only lets a new level through
// to q once it has been seen for STABLE_CYCLES consecutive edges.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    sync_debounce_if.slave (d_in in; q, rise, fall, busy out)
module sync_debounce #(
   parameter int unsigned SYNC_STAGES   = 2,    // >= 2
   parameter int unsigned STABLE_CYCLES = 4,    // >= 1
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   sync_debounce_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] StStable = 1'b0;
   localparam logic [0:0] StCheck  = 1'b1;

   logic [SYNC_STAGES-1:0] s_q, s_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [0:0]             state_q, state_d;
   logic                   q_q, q_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   // Only the last stage is used; s_q[0] is the one allowed to go metastable.
   assign s_d = {s_q[SYNC_STAGES-2:0], bus.d_in};
   assign s   = s_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         StStable: begin
            if (s == q_q) begin
               cnt_d = '0;
            end else if (STABLE_CYCLES == 1) begin
               // Single-cycle qualification: accept immediately, no CHECK visit.
               q_d    = s;
               rise_d = s;
               fall_d = ~s;
            end else begin
               state_d = StCheck;
               cnt_d   = CNT_ONE;
            end
         end
         StCheck: begin
            // A return to q takes priority over reaching the terminal count.
            if (s == q_q) begin
               state_d = StStable;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = StStable;
               cnt_d   = '0;
               q_d     = s;
               rise_d  = s;
               fall_d  = ~s;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = StStable;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q     <= {SYNC_STAGES{INIT_LEVEL}};
         cnt_q   <= '0;
         state_q <= StStable;
         q_q     <= INIT_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign bus.q    = q_q;
   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
   // Straight decode of the state flop, so busy cannot glitch.
   assign bus.busy = (state_q == StCheck);

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: drives two sync_debounce instances (defaults, and
// SYNC_STAGES=3 / STABLE_CYCLES=1) from one raw level and compares every
// output each cycle against a window-based reference model built on the
// history of sampled d_in values.
module tb_sync_debounce;
   timeunit 1ns;
   timeprecision 100ps;

   localparam int NCFG  = 2;
   localparam int SYNC0 = 2;
   localparam int STAB0 = 4;
   localparam int SYNC1 = 3;
   localparam int STAB1 = 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic d_in  = 1'b0;
   bit   stop_drv;

   always #5 clk = ~clk;

   sync_debounce_if bus0 ();
   sync_debounce_if bus1 ();
   assign bus0.d_in = d_in;
   assign bus1.d_in = d_in;

   sync_debounce #(
      .SYNC_STAGES  (SYNC0),
      .STABLE_CYCLES(STAB0),
      .INIT_LEVEL   (1'b0)
   ) dut0 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus0)
   );

   sync_debounce #(
      .SYNC_STAGES  (SYNC1),
      .STABLE_CYCLES(STAB1),
      .INIT_LEVEL   (1'b0)
   ) dut1 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: q flips when the last STABLE_CYCLES values seen at the
   // synchronizer output all differ from the current q.
   bit hist[$];
   bit mq[NCFG];
   bit mrise[NCFG];
   bit mfall[NCFG];
   bit mbusy[NCFG];
   int sync_c[NCFG] = '{SYNC0, SYNC1};
   int stab_c[NCFG] = '{STAB0, STAB1};

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < 32; i++) hist.push_back(1'b0);
      for (int c = 0; c < NCFG; c++) begin
         mq[c]    = 1'b0;
         mrise[c] = 1'b0;
         mfall[c] = 1'b0;
         mbusy[c] = 1'b0;
      end
   endfunction

   function automatic void model_edge(bit din);
      int  last;
      bit  s_now;
      bit  all_mis;
      hist.push_back(din);
      if (hist.size() > 64) void'(hist.pop_front());
      last = hist.size() - 1;
      for (int c = 0; c < NCFG; c++) begin
         // Value sampled SYNC edges ago is what the FSM sees on this edge.
         s_now   = hist[last - sync_c[c]];
         all_mis = 1'b1;
         for (int j = 0; j < stab_c[c]; j++)
            if (hist[last - sync_c[c] - j] == mq[c]) all_mis = 1'b0;
         mrise[c] = all_mis && !mq[c];
         mfall[c] = all_mis && mq[c];
         mbusy[c] = (stab_c[c] > 1) && !all_mis && (s_now != mq[c]);
         if (all_mis) mq[c] = ~mq[c];
      end
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " q0"},    bus0.q,    mq[0]);
      check({tag, " rise0"}, bus0.rise, mrise[0]);
      check({tag, " fall0"}, bus0.fall, mfall[0]);
      check({tag, " busy0"}, bus0.busy, mbusy[0]);
      check({tag, " excl0"}, bus0.rise & bus0.fall, 1'b0);
      check({tag, " q1"},    bus1.q,    mq[1]);
      check({tag, " rise1"}, bus1.rise, mrise[1]);
      check({tag, " fall1"}, bus1.fall, mfall[1]);
      check({tag, " busy1"}, bus1.busy, mbusy[1]);
      check({tag, " excl1"}, bus1.rise & bus1.fall, 1'b0);
   endtask

   // One clock edge: advance the model, then sample outputs 1ns later.
   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(d_in);
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges and confirm outputs clear before the next one.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
   endtask

   initial begin
      stop_drv = 1'b0;
      reset    = 1'b1;
      d_in     = 1'b0;
      model_reset();
      #1;
      check_all("rst_initial");

      // Reset held while d_in toggles.
      repeat (6) begin
         d_in = 1'($urandom);
         tick("rst_hold");
      end
      d_in  = 1'b0;
      reset = 1'b0;
      repeat (4) tick("settle");

      // Clean rise: busy at k+2, q/rise at k+5, rise gone at k+6.
      d_in = 1'b1;
      repeat (3) tick("rise");
      check("rise busy@k+2", bus0.busy, 1'b1);
      repeat (3) tick("rise");
      check("rise q@k+5", bus0.q, 1'b1);
      check("rise rise@k+5", bus0.rise, 1'b1);
      tick("rise");
      check("rise rise@k+6", bus0.rise, 1'b0);
      check("rise fall@k+6", bus0.fall, 1'b0);

      // Corner config: fall on 4th edge with no busy; defaults fall on 6th.
      d_in = 1'b0;
      repeat (4) tick("fall");
      check("corner q1@4", bus1.q, 1'b0);
      check("corner fall1@4", bus1.fall, 1'b1);
      check("corner busy1@4", bus1.busy, 1'b0);
      repeat (2) tick("fall");
      check("fall q0@6", bus0.q, 1'b0);
      check("fall fall0@6", bus0.fall, 1'b1);
      repeat (4) tick("settle");

      // Glitch of 3 cycles rejected by the default instance.
      d_in = 1'b1;
      repeat (3) tick("glitch3");
      check("glitch3 busy0", bus0.busy, 1'b1);
      d_in = 1'b0;
      repeat (8) tick("glitch3");
      check("glitch3 q0", bus0.q, 1'b0);

      // 4 cycles high is the minimum accepted pulse; release falls 6 edges later.
      d_in = 1'b1;
      repeat (4) tick("pulse4");
      d_in = 1'b0;
      repeat (2) tick("pulse4");
      check("pulse4 q0", bus0.q, 1'b1);
      check("pulse4 rise0", bus0.rise, 1'b1);
      repeat (4) tick("pulse4");
      check("pulse4 fall0", bus0.fall, 1'b1);
      check("pulse4 q0 low", bus0.q, 1'b0);
      repeat (4) tick("settle");

      // Reset mid-count (busy high, count at 2), then re-qualify after release.
      d_in = 1'b1;
      repeat (4) tick("midrst");
      check("midrst busy0 before", bus0.busy, 1'b1);
      async_reset();
      check("midrst busy0 after", bus0.busy, 1'b0);
      check("midrst q0 after", bus0.q, 1'b0);
      tick("midrst");
      reset = 1'b0;
      repeat (5) tick("midrst");
      check("midrst q0 early", bus0.q, 1'b0);
      tick("midrst");
      check("midrst q0@6", bus0.q, 1'b1);
      check("midrst rise0@6", bus0.rise, 1'b1);

      // Random soak: d_in changes at half-unit offsets so it never lands on an edge.
      fork
         begin
            #0.5;
            while (!stop_drv) begin
               #($urandom_range(20, 1));
               d_in = 1'($urandom);
            end
         end
      join_none
      for (int i = 0; i < 1500; i++) begin
         tick("soak");
         if ($urandom_range(299, 0) == 0) begin
            async_reset();
            tick("soak_rst");
            reset = 1'b0;
         end
      end
      stop_drv = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input conditioning stage placed directly upstream of the `DFF` register: it takes an asynchronous, possibly bouncing single-bit level and delivers a clean, clock-synchronous level for the `DFF` `d` input. It also produces one-cycle rise and fall pulses. Internally it has a multi-flop synchronizer, a stability counter, and a two-state FSM.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth; legal values ≥ 2.
- `STABLE_CYCLES`, 4: number of consecutive mismatch cycles required before `q` changes; legal values ≥ 1.
- `INIT_LEVEL`, 1'b0: reset value of the synchronizer flops and of `q`.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset; clears state immediately, with no clock edge needed.
- `d_in`  input  1  asynchronous raw level.
- `q`  output  1  debounced, synchronous level; registered.
- `rise`  output  1  one-cycle pulse in the cycle `q` goes 0→1; registered.
- `fall`  output  1  one-cycle pulse in the cycle `q` goes 1→0; registered.
- `busy`  output  1  high while a candidate change is being counted (FSM in CHECK).

## Operation
- **Synchronizer:** `s[0..SYNC_STAGES-1]` shift register; `s[0]<=d_in`. Only `s[SYNC_STAGES-1]` (call it `s`) is used downstream.
- **Counter:** `cnt` width `$clog2(STABLE_CYCLES+1)`, unsigned. It never exceeds `STABLE_CYCLES-1` and never wraps.
- **FSM states:** STABLE, CHECK.
  - STABLE, `s==q`: stay; `cnt=0`.
  - STABLE, `s!=q`, `STABLE_CYCLES==1`: `q<=s`, pulse, stay in STABLE.
  - STABLE, `s!=q`, `STABLE_CYCLES>1`: go to CHECK, `cnt<=1`.
  - CHECK, `s==q` (glitch ended): go to STABLE, `cnt<=0`; `q` unchanged, no pulse.
  - CHECK, `s!=q`, `cnt<STABLE_CYCLES-1`: `cnt<=cnt+1`.
  - CHECK, `s!=q`, `cnt==STABLE_CYCLES-1`: `q<=s`, `cnt<=0`, go to STABLE, pulse.
- **Pulses:**
  - `rise<=1` on the edge where `q` goes 0→1; `fall<=1` on the edge where `q` goes 1→0. Otherwise both are 0.
  - `rise` and `fall` are never high together, and each lasts exactly one cycle.
- `busy` = (state==CHECK). It is decoded from the state register, so it is glitch-free.
- **Reset:** asserting `reset` at any time, including mid-count, forces:
  - all `s[i]=INIT_LEVEL`, `q=INIT_LEVEL`;
  - `cnt=0`, state=STABLE;
  - `rise=0`, `fall=0`, `busy=0`.
- After reset deassertion no pulse is emitted, even if `d_in` differs from `INIT_LEVEL`. That difference is treated as a normal change and counted, so a pulse can follow later through the normal path.

## Timing
- **Latency:** let edge k be the first edge that samples a new `d_in` level which then stays constant. `q`, `rise` and `fall` update on edge `k+SYNC_STAGES+STABLE_CYCLES-1`. This is `SYNC_STAGES+STABLE_CYCLES` edges, counting edge k. With defaults the change appears on the 6th edge.
- **Busy window:** `busy` rises on edge `k+SYNC_STAGES` (only when `STABLE_CYCLES>1`) and falls on the same edge `q` updates.
- **Glitch rejection:** a level change visible at `s` for fewer than `STABLE_CYCLES` consecutive edges never reaches `q`.
- **Minimum pulse:** a change visible at `s` for exactly `STABLE_CYCLES` edges is accepted.
- **Simultaneous events:** if `s` returns to `q` on the same edge the counter would hit its terminal count, the return wins. No change is made to `q`.
- `d_in` may change at any time relative to `clk`. Metastability is confined to `s[0]`.

## Test plan
- **Reset:** hold `reset=1` with `d_in` toggling randomly → `q=0`, `rise=0`, `fall=0`, `busy=0` throughout. Assert `reset` asynchronously between edges → outputs clear before the next edge.
- **Clean rise (defaults):** `d_in` 0→1 held before edge k → `busy=1` at edge k+2; `q=1` and `rise=1` at edge k+5; `rise=0` at edge k+6; `fall` stays 0.
- **Glitch reject:** `d_in` high for 3 cycles, then low → `busy` pulses high, `q` stays 0, no `rise`. Repeat with 4 cycles high → `q=1` and `rise` asserted; then the release is accepted and `fall` fires 6 edges after `d_in` returns low.
- **Reset mid-count:** start a 0→1 change, then assert `reset` while `busy=1` (`cnt=2`) → `q=0`, `cnt=0`, `busy=0`. After release with `d_in` still 1 → `q=1` and `rise` on the 6th edge after release.
- **Parameter corner:** `STABLE_CYCLES=1`, `SYNC_STAGES=3`, step `d_in` 1→0 from a settled high → `busy` never asserts; `q=0` and `fall=1` on the 4th edge.
- **Random soak:** random `d_in` stimulus with random hold times of 1–20 time units, checked against a cycle-accurate reference model → `q` matches every cycle; each `rise`/`fall` pulse coincides with a `q` transition; no overlapping pulses.
